// File: rtl/sh4a_pkg.sv
// Shared types, sizes and the logical-to-physical bank map
// for the SH-4A integer issue stage and its scoreboard.
package sh4a_pkg;

    localparam int NUM_PHYS_REGS = 24;
    localparam int IDX_W         = 5;
    localparam int LOG_W         = 4;
    localparam int LAT_W         = 2;

    localparam logic [IDX_W-1:0] REG0_BANK0 = 5'd0;
    localparam logic [IDX_W-1:0] REG7_BANK0 = 5'd7;
    localparam logic [IDX_W-1:0] REG0_BANK1 = 5'd16;
    localparam logic [IDX_W-1:0] REG7_BANK1 = 5'd23;

    localparam logic [IDX_W-1:0] NPR_IDX = IDX_W'(NUM_PHYS_REGS);

    // R0-R7 move to the bank1 copies at 16-23 when SR.RB is set
    function automatic logic [IDX_W-1:0] bank_map(
        input logic             bank,
        input logic [LOG_W-1:0] idx
    );
        logic [IDX_W-1:0] w_ext;
        w_ext = {1'b0, idx};
        if (bank && (w_ext <= REG7_BANK0))
            return REG0_BANK1 + w_ext;
        return w_ext;
    endfunction

endpackage

// File: rtl/sh4a_scoreboard.sv
// Busy-bit scoreboard: two set ports (accepted writes), two clear ports
// (writebacks), four lookups. Ports: i_set_*, i_clr_*, i_lk_idx/o_lk_busy, o_busy.
module sh4a_scoreboard
    import sh4a_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [1:0]                  i_set_en,
    input  logic [1:0][IDX_W-1:0]       i_set_idx,
    input  logic [1:0]                  i_clr_en,
    input  logic [1:0][IDX_W-1:0]       i_clr_idx,
    input  logic [3:0][IDX_W-1:0]       i_lk_idx,
    output logic [3:0]                  o_lk_busy,
    output logic [NUM_PHYS_REGS-1:0]    o_busy
);

    logic [NUM_PHYS_REGS-1:0] r_busy;
    logic [NUM_PHYS_REGS-1:0] w_set;
    logic [NUM_PHYS_REGS-1:0] w_clr;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int k = 0; k < 2; k++) begin
            if (i_set_en[k] && (i_set_idx[k] < NPR_IDX))
                w_set[i_set_idx[k]] = 1'b1;
            if (i_clr_en[k] && (i_clr_idx[k] < NPR_IDX))
                w_clr[i_clr_idx[k]] = 1'b1;
        end
    end

    // a set in the same cycle as a clear of the same bit wins
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_busy <= '0;
        else
            r_busy <= (r_busy & ~w_clr) | w_set;
    end

    // lookups see the registered vector: no writeback bypass
    always_comb begin
        o_lk_busy = '0;
        for (int j = 0; j < 4; j++) begin
            if (i_lk_idx[j] < NPR_IDX)
                o_lk_busy[j] = r_busy[i_lk_idx[j]];
        end
    end

    assign o_busy = r_busy;

`ifdef FORMAL
    for (genvar k = 0; k < 2; k++) begin : g_wb_chk
        a_wb_busy: assert property (
            @(posedge i_clk) disable iff (i_reset)
            (i_clr_en[k] && (i_clr_idx[k] < NPR_IDX))
                |-> r_busy[i_clr_idx[k]]
        );
    end
`endif

endmodule

// File: rtl/sh4a_issue_stage.sv
// Dual-issue stage: hazard check, pairing, pipe steering, registered issue.
// Ports: decoder pair in, o_dec_consume, writeback in, pipe0/pipe1 issue out.
module sh4a_issue_stage
    import sh4a_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_bank_sel,
    input  logic [1:0]            i_dec_valid,
    input  logic [1:0][LOG_W-1:0] i_dec_rs0,
    input  logic [1:0][LOG_W-1:0] i_dec_rs1,
    input  logic [1:0]            i_dec_use_rs0,
    input  logic [1:0]            i_dec_use_rs1,
    input  logic [1:0][LOG_W-1:0] i_dec_rd,
    input  logic [1:0]            i_dec_wr,
    input  logic [1:0]            i_dec_pipe0_only,
    output logic [1:0]            o_dec_consume,
    input  logic                  i_flush,
    input  logic [1:0]            i_wb_valid,
    input  logic [1:0][IDX_W-1:0] i_wb_idx,
    output logic                  o_iss_valid_p0,
    output logic                  o_iss_valid_p1,
    output logic                  o_iss_slot_p0,
    output logic                  o_iss_slot_p1,
    output logic [IDX_W-1:0]      o_int_idx_read0_pipe0,
    output logic [IDX_W-1:0]      o_int_idx_read1_pipe0,
    output logic [IDX_W-1:0]      o_int_idx_read0_pipe1,
    output logic [IDX_W-1:0]      o_int_idx_read1_pipe1,
    output logic [IDX_W-1:0]      o_iss_rd_p0,
    output logic [IDX_W-1:0]      o_iss_rd_p1
);

    logic [1:0][IDX_W-1:0]    w_rs0;
    logic [1:0][IDX_W-1:0]    w_rs1;
    logic [1:0][IDX_W-1:0]    w_rd;
    logic [NUM_PHYS_REGS-1:0] w_busy;
    logic [3:0]               w_lk_busy;
    logic [1:0]               w_haz;
    logic                     w_dep;
    logic                     w_waw;
    logic                     w_acc0;
    logic                     w_acc1;
    logic                     w_p0_slot;
    logic                     w_p1_slot;

    logic                     r_v0;
    logic                     r_v1;
    logic                     r_slot0;
    logic                     r_slot1;
    logic [IDX_W-1:0]         r_r0_p0;
    logic [IDX_W-1:0]         r_r1_p0;
    logic [IDX_W-1:0]         r_r0_p1;
    logic [IDX_W-1:0]         r_r1_p1;
    logic [IDX_W-1:0]         r_rd_p0;
    logic [IDX_W-1:0]         r_rd_p1;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_rs0[s] = bank_map(i_bank_sel, i_dec_rs0[s]);
            w_rs1[s] = bank_map(i_bank_sel, i_dec_rs1[s]);
            w_rd[s]  = bank_map(i_bank_sel, i_dec_rd[s]);
        end
    end

    sh4a_scoreboard u_sb (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_set_en  ({w_acc1 & i_dec_wr[1], w_acc0 & i_dec_wr[0]}),
        .i_set_idx (w_rd),
        .i_clr_en  (i_wb_valid),
        .i_clr_idx (i_wb_idx),
        .i_lk_idx  ({w_rs1[1], w_rs0[1], w_rs1[0], w_rs0[0]}),
        .o_lk_busy (w_lk_busy),
        .o_busy    (w_busy)
    );

    // phys rd is always below 24, so the direct bit select is safe
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_haz[s] = (i_dec_use_rs0[s] & w_lk_busy[2*s])
                     | (i_dec_use_rs1[s] & w_lk_busy[2*s+1])
                     | (i_dec_wr[s] & w_busy[w_rd[s]]);
        end
    end

    // intra-pair RAW and WAW
    assign w_dep = i_dec_wr[0]
                 & ((i_dec_use_rs0[1] & (w_rs0[1] == w_rd[0]))
                 |  (i_dec_use_rs1[1] & (w_rs1[1] == w_rd[0])));
    assign w_waw = i_dec_wr[0] & i_dec_wr[1] & (w_rd[0] == w_rd[1]);

    assign w_acc0 = i_dec_valid[0] & ~i_flush & ~w_haz[0];
    assign w_acc1 = w_acc0 & i_dec_valid[1] & ~w_haz[1]
                  & ~w_dep & ~w_waw
                  & ~(i_dec_pipe0_only[0] & i_dec_pipe0_only[1]);

    // a pipe0-only slot1 swaps the pair; a lone slot0 stays on pipe0
    assign w_p0_slot = w_acc1 & i_dec_pipe0_only[1];
    assign w_p1_slot = ~w_p0_slot;

    always_comb begin
        o_dec_consume = 2'd0;
        unique case (1'b1)
            w_acc1:            o_dec_consume = 2'd2;
            w_acc0 & ~w_acc1:  o_dec_consume = 2'd1;
            default:           o_dec_consume = 2'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_slot0 <= 1'b0;
            r_slot1 <= 1'b0;
            r_r0_p0 <= '0;
            r_r1_p0 <= '0;
            r_r0_p1 <= '0;
            r_r1_p1 <= '0;
            r_rd_p0 <= '0;
            r_rd_p1 <= '0;
        end else begin
            r_v0 <= w_acc0;
            r_v1 <= w_acc1;
            if (w_acc0) begin
                r_slot0 <= w_p0_slot;
                r_r0_p0 <= w_rs0[w_p0_slot];
                r_r1_p0 <= w_rs1[w_p0_slot];
                r_rd_p0 <= w_rd[w_p0_slot];
            end
            if (w_acc1) begin
                r_slot1 <= w_p1_slot;
                r_r0_p1 <= w_rs0[w_p1_slot];
                r_r1_p1 <= w_rs1[w_p1_slot];
                r_rd_p1 <= w_rd[w_p1_slot];
            end
        end
    end

    assign o_iss_valid_p0        = r_v0;
    assign o_iss_valid_p1        = r_v1;
    assign o_iss_slot_p0         = r_slot0;
    assign o_iss_slot_p1         = r_slot1;
    assign o_int_idx_read0_pipe0 = r_r0_p0;
    assign o_int_idx_read1_pipe0 = r_r1_p0;
    assign o_int_idx_read0_pipe1 = r_r0_p1;
    assign o_int_idx_read1_pipe1 = r_r1_p1;
    assign o_iss_rd_p0           = r_rd_p0;
    assign o_iss_rd_p1           = r_rd_p1;

endmodule
